// File: rtl/display_scan_controller.sv
// Four-digit time-multiplexed scan driver for a seven-segment decoder.
// Display values are double-buffered and swapped only at frame boundaries.
module display_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        LOAD,
  input  logic [15:0] DIGITS_IN,
  input  logic [3:0]  DOTS_IN,
  input  logic        LZ_EN,
  output logic [3:0]  BINARY,
  output logic [1:0]  SEGMENT,
  output logic        DOT,
  output logic        BLANK,
  output logic        PENDING,
  output logic        FRAME_DONE
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [15:0] act_digits;
  logic [3:0]  act_dots;
  logic        act_lz;
  logic [15:0] pend_digits;
  logic [3:0]  pend_dots;
  logic        pend_lz;

  logic        tick;
  logic        swap;
  logic [1:0]  idx_nxt;
  logic [15:0] digits_nxt;
  logic [3:0]  dots_nxt;
  logic        lz_nxt;
  logic [3:0]  blank_mask;

  assign tick    = (cnt == CNT_MAX);
  assign swap    = tick && (idx == 2'd3) && PENDING;
  assign idx_nxt = idx + 2'd1;

  // Post-swap view of the active bank, so digit 0 of a new frame already
  // shows the freshly swapped values.
  // NOTE: every always_comb output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    digits_nxt = act_digits;
    dots_nxt   = act_dots;
    lz_nxt     = act_lz;
    if (swap) begin
      digits_nxt = pend_digits;
      dots_nxt   = pend_dots;
      lz_nxt     = pend_lz;
    end
  end

  // A digit goes dark when it and every higher digit are zero; digit 0 never does.
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = lz_nxt && (digits_nxt[15:12] == 4'h0);
    blank_mask[2] = blank_mask[3] && (digits_nxt[11:8] == 4'h0);
    blank_mask[1] = blank_mask[2] && (digits_nxt[7:4] == 4'h0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx_nxt;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      act_digits  <= 16'h0000;
      act_dots    <= 4'b1111;
      act_lz      <= 1'b0;
      pend_digits <= 16'h0000;
      pend_dots   <= 4'b1111;
      pend_lz     <= 1'b0;
      PENDING     <= 1'b0;
    end else begin
      if (swap) begin
        act_digits <= pend_digits;
        act_dots   <= pend_dots;
        act_lz     <= pend_lz;
      end
      // A load coinciding with the swap refills the pending bank after the
      // old contents have been applied, keeping PENDING set.
      if (LOAD) begin
        pend_digits <= DIGITS_IN;
        pend_dots   <= DOTS_IN;
        pend_lz     <= LZ_EN;
        PENDING     <= 1'b1;
      end else if (swap) begin
        PENDING <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      BINARY     <= 4'h0;
      SEGMENT    <= 2'd0;
      DOT        <= 1'b1;
      BLANK      <= 1'b1;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= tick && (idx == 2'd3);
      if (tick) begin
        SEGMENT <= idx_nxt;
        BINARY  <= digits_nxt[{idx_nxt, 2'b00} +: 4];
        DOT     <= dots_nxt[idx_nxt];
        BLANK   <= blank_mask[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with REFRESH_DIV = 4: scan order,
// deferred/overwritten/coincident loads, leading-zero blanking and reset.
module tb_display_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dots_in;
  logic        lz_en;
  logic [3:0]  binary;
  logic [1:0]  segment;
  logic        dot;
  logic        blank;
  logic        pending;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;  // rising edges since reset release

  display_scan_controller #(.REFRESH_DIV(4), .CNT_W(2)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .LOAD       (load),
    .DIGITS_IN  (digits_in),
    .DOTS_IN    (dots_in),
    .LZ_EN      (lz_en),
    .BINARY     (binary),
    .SEGMENT    (segment),
    .DOT        (dot),
    .BLANK      (blank),
    .PENDING    (pending),
    .FRAME_DONE (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    if (target < k) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_to: already at edge %0d, target %0d", k, target);
    end
    while (k < target) step();
  endtask

  // Present one load strobe so it is captured on edge k+1.
  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic lz);
    load = 1'b1; digits_in = d; dots_in = p; lz_en = lz;
    step();
    load = 1'b0; digits_in = 16'hDEAD; dots_in = 4'b0000; lz_en = 1'b1;
  endtask

  task automatic check_slot(input int at, input logic [1:0] seg, input logic [3:0] bin,
                            input logic dt, input logic blk);
    run_to(at);
    check("segment", 32'(segment), 32'(seg));
    check("binary",  32'(binary),  32'(bin));
    check("dot",     32'(dot),     32'(dt));
    check("blank",   32'(blank),   32'(blk));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_binary"},  32'(binary),     32'h0);
    check({tag, "_segment"}, 32'(segment),    32'h0);
    check({tag, "_dot"},     32'(dot),        32'h1);
    check({tag, "_blank"},   32'(blank),      32'h1);
    check({tag, "_pending"}, 32'(pending),    32'h0);
    check({tag, "_fdone"},   32'(frame_done), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; digits_in = 16'h0; dots_in = 4'hF; lz_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    k = 0;

    // Idle scan: segment advances every 4 edges, frame_done on multiples of 16.
    for (int e = 1; e <= 36; e++) begin
      step();
      check("idle_segment", 32'(segment), 32'((e / 4) % 4));
      check("idle_fdone",   32'(frame_done), 32'(((e % 16) == 0) ? 1 : 0));
      check("idle_blank",   32'(blank), 32'((e < 4) ? 1 : 0));
    end

    // Deferred load during idx 1; old (zero) values persist until edge 48.
    do_load(16'h1234, 4'b1011, 1'b0);
    check("defer_pending", 32'(pending), 32'h1);
    check_slot(40, 2'd2, 4'h0, 1'b1, 1'b0);
    check_slot(44, 2'd3, 4'h0, 1'b1, 1'b0);
    check("defer_still_pending", 32'(pending), 32'h1);
    check_slot(48, 2'd0, 4'h4, 1'b1, 1'b0);
    check("defer_pending_clr", 32'(pending), 32'h0);
    check("defer_fdone", 32'(frame_done), 32'h1);
    check_slot(52, 2'd1, 4'h3, 1'b1, 1'b0);
    check_slot(56, 2'd2, 4'h2, 1'b0, 1'b0);
    check_slot(60, 2'd3, 4'h1, 1'b1, 1'b0);

    // Two loads in one frame: only the second is displayed.
    run_to(65);
    do_load(16'h1111, 4'b1111, 1'b0);
    check_slot(68, 2'd1, 4'h3, 1'b1, 1'b0);
    run_to(69);
    do_load(16'h2222, 4'b1111, 1'b0);
    check("ovr_pending", 32'(pending), 32'h1);
    check_slot(80, 2'd0, 4'h2, 1'b1, 1'b0);
    check_slot(84, 2'd1, 4'h2, 1'b1, 1'b0);
    check_slot(88, 2'd2, 4'h2, 1'b1, 1'b0);
    check_slot(92, 2'd3, 4'h2, 1'b1, 1'b0);
    check("ovr_pending_clr", 32'(pending), 32'h0);

    // Load coinciding with the swap tick (edge 112).
    run_to(97);
    do_load(16'hAAAA, 4'b1111, 1'b0);
    run_to(111);
    do_load(16'h5555, 4'b1111, 1'b0);
    check("coin_binary", 32'(binary), 32'hA);
    check("coin_pending", 32'(pending), 32'h1);
    check_slot(120, 2'd2, 4'hA, 1'b1, 1'b0);
    check_slot(124, 2'd3, 4'hA, 1'b1, 1'b0);
    check_slot(128, 2'd0, 4'h5, 1'b1, 1'b0);
    check("coin_pending_clr", 32'(pending), 32'h0);
    check_slot(140, 2'd3, 4'h5, 1'b1, 1'b0);

    // Leading-zero suppression.
    run_to(141);
    do_load(16'h0040, 4'b1111, 1'b1);
    check_slot(144, 2'd0, 4'h0, 1'b1, 1'b0);
    check_slot(148, 2'd1, 4'h4, 1'b1, 1'b0);
    check_slot(152, 2'd2, 4'h0, 1'b1, 1'b1);
    check_slot(156, 2'd3, 4'h0, 1'b1, 1'b1);
    run_to(157);
    do_load(16'h0000, 4'b0110, 1'b1);
    check_slot(160, 2'd0, 4'h0, 1'b0, 1'b0);
    check_slot(164, 2'd1, 4'h0, 1'b1, 1'b1);
    check_slot(168, 2'd2, 4'h0, 1'b1, 1'b1);
    check_slot(172, 2'd3, 4'h0, 1'b0, 1'b1);
    run_to(173);
    do_load(16'h0000, 4'b1111, 1'b0);
    check_slot(176, 2'd0, 4'h0, 1'b1, 1'b0);
    check_slot(180, 2'd1, 4'h0, 1'b1, 1'b0);
    check_slot(184, 2'd2, 4'h0, 1'b1, 1'b0);

    // Mid-frame reset with idx 2 and a pending bank.
    do_load(16'h9876, 4'b0000, 1'b0);
    check("mid_pending", 32'(pending), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    k = 0;
    check_slot(3, 2'd0, 4'h0, 1'b1, 1'b1);
    check_slot(4, 2'd1, 4'h0, 1'b1, 1'b0);
    check_slot(16, 2'd0, 4'h0, 1'b1, 1'b0);
    check("post_fdone", 32'(frame_done), 32'h1);
    check("post_pending", 32'(pending), 32'h0);
    check_slot(24, 2'd2, 4'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexing driver that feeds the four-digit seven-segment decoder. Holds four 4-bit digit values plus per-digit decimal points. Steps through digits 0..3 at a parameterised refresh rate and presents `BINARY`, `SEGMENT`, `DOT` and a per-digit `BLANK` to the decoder. New display values are double-buffered and swapped only at a frame boundary, so a frame never shows a mix of old and new values.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot; legal minimum 2 (100 MHz gives 1 kHz per digit, 250 Hz per frame).
- `CNT_W`, default 17: prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

- `CLK`  in  1  single system clock; all state on rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `LOAD`  in  1  single-cycle strobe; captures `DIGITS_IN`, `DOTS_IN` and `LZ_EN` into the pending bank.
- `DIGITS_IN`  in  16  digit n = `DIGITS_IN[4n+3:4n]`, values 0x0–0xF.
- `DOTS_IN`  in  4  bit n = decimal-point level for digit n; active-low (0 = lit).
- `LZ_EN`  in  1  leading-zero suppression enable.
- `BINARY`  out  4  value of the currently scanned digit.
- `SEGMENT`  out  2  index of the currently scanned digit, 0–3.
- `DOT`  out  1  decimal-point level for the current digit; passed through unchanged.
- `BLANK`  out  1  high = current digit must be dark; the top level ORs this into all anode selects.
- `PENDING`  out  1  high while a loaded bank is waiting for the frame boundary.
- `FRAME_DONE`  out  1  one-cycle pulse; asserts when the scan wraps from digit 3 to digit 0.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and then wraps. `tick` = (`cnt` == REFRESH_DIV-1).
- Digit index `idx` (2 bits) increments on `tick` and wraps 3→0.
- Banks:
  - Active bank (digits, dots, lz) drives the outputs.
  - Pending bank plus `PENDING` flag hold loaded data.
  - `LOAD` writes the pending bank and sets `PENDING` on the same edge. A second `LOAD` before the swap overwrites the pending bank; last write wins.
- Swap:
  - On a `tick` where `idx` == 3 and `PENDING` = 1, the active bank takes the pending bank.
  - Digit 0 of the new frame is driven from the new values.
  - `PENDING` clears on that edge unless `LOAD` is also high in that cycle. In that case the old pending data is applied, the new `LOAD` data enters the pending bank, and `PENDING` stays 1.
- Output registers `BINARY`, `SEGMENT`, `DOT` and `BLANK` update on the `tick` edge from the next `idx` and the post-swap active bank. They are constant between ticks.
- Leading-zero suppression, evaluated on the active bank:
  - Digit n (n = 3, 2, 1) is suppressed when `lz` = 1, digit n == 0, and all higher digits == 0.
  - Digit 0 is never suppressed.
  - Suppressed digit → `BLANK` = 1. `BINARY` and `DOT` still carry the stored values.
- `FRAME_DONE` is registered high for exactly one cycle following the 3→0 `tick` edge, whether or not a swap occurred.
- `DIGITS_IN`, `DOTS_IN` and `LZ_EN` are ignored when `LOAD` = 0.

## Timing
- Reset values (asynchronous, while `RESET_N` = 0):
  - Counters: `cnt` = 0, `idx` = 0.
  - Active and pending digits = 0, dots = 4'b1111, lz = 0.
  - Outputs: `PENDING` = 0, `FRAME_DONE` = 0, `BINARY` = 0, `SEGMENT` = 0, `DOT` = 1, `BLANK` = 1.
- First `tick` occurs REFRESH_DIV cycles after reset release.
  - On that edge `SEGMENT` goes 0→1, because the outputs present the next `idx`.
  - `BLANK` follows the suppression rule from that edge on.
- Each digit slot lasts exactly REFRESH_DIV cycles. A frame lasts 4×REFRESH_DIV cycles.
- `FRAME_DONE` spacing is 4×REFRESH_DIV cycles.
- `LOAD`-to-display latency: `PENDING` is 1 on the cycle after `LOAD`. New values appear on the next 3→0 `tick` edge, at most 4×REFRESH_DIV cycles later.
- Reset asserted mid-frame or mid-pending immediately returns all state to reset values. Pending data is discarded.
- No combinational path from any input to any output.

## Test plan
- Reset/idle, REFRESH_DIV = 4:
  - Release `RESET_N` → `SEGMENT` = 0, `BLANK` = 1 for 4 cycles.
  - Then `SEGMENT` sequence 1, 2, 3, 0, 1, … with each value held 4 cycles.
  - `FRAME_DONE` pulses every 16 cycles.
- Deferred load:
  - `LOAD` with `DIGITS_IN` = 0x1234, `DOTS_IN` = 4'b1011 while `idx` = 1 → `PENDING` = 1 the next cycle.
  - Old values persist until the 3→0 tick.
  - Then `SEGMENT` 0/1/2/3 present `BINARY` 4/3/2/1 with `DOT` 1/1/0/1.
  - `PENDING` returns to 0.
- Overwrite: two LOADs (0x1111, then 0x2222) within one frame → only 0x2222 is ever displayed.
- Simultaneous `LOAD` and swap:
  - Pending 0xAAAA; `LOAD` 0x5555 in the 3→0 tick cycle.
  - Frame shows 0xAAAA and `PENDING` stays 1.
  - Next frame shows 0x5555.
- Leading-zero suppression:
  - `LZ_EN` = 1, `DIGITS_IN` = 0x0040 → `BLANK` = 1 on digits 3 and 2, 0 on digits 1 and 0.
  - 0x0000 → only digit 0 unblanked.
  - 0x0000 with `LZ_EN` = 0 → all digits unblanked.
- Mid-frame reset: assert `RESET_N` = 0 for 1 cycle with `idx` = 2 and `PENDING` = 1 → all outputs at reset values immediately, pending data never displayed.
